// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access unit.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as a word)
//   - FSM state encodings (IDLE, READ, WRITE, RESP)
//   - lane widths used by extraction and merge
//   - is_misaligned(): alignment rule, used only when MEM_ALIGN_CHECK_EN is defined
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_READ  = 2'd1;
   localparam state_t ST_WRITE = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = 32;

   // Halves need addr[0]=0; words (2'b10 and 2'b11) need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      if (size[1]) begin
         mis = |addr_lo;
      end else if (size == SZ_HALF) begin
         mis = addr_lo[0];
      end else begin
         mis = 1'b0;
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte/half lane handling.
// Ports:
//   size       in  2   access size (SZ_*; 2'b11 treated as word)
//   sgn        in  1   sign-extend sub-word loads
//   addr_lo    in  2   byte offset within the word
//   rword      in  32  word read from memory
//   wdata      in  32  right-justified store data
//   load_data  out 32  extracted and extended load result
//   merge_data out 32  rword with the addressed lane replaced by wdata (word: wdata)
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [BYTE_W-1:0] lane_b;
   logic [HALF_W-1:0] lane_h;

   always_comb begin
      lane_b = rword[7:0];
      unique case (addr_lo)
         2'd0: lane_b = rword[7:0];
         2'd1: lane_b = rword[15:8];
         2'd2: lane_b = rword[23:16];
         2'd3: lane_b = rword[31:24];
         default: lane_b = rword[7:0];
      endcase
      // Halves select on addr[1] only; addr[0] is ignored here.
      lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   always_comb begin
      load_data  = rword;
      merge_data = wdata;
      if (size == SZ_BYTE) begin
         load_data  = {{(WORD_W - BYTE_W){sgn & lane_b[BYTE_W-1]}}, lane_b};
         merge_data = rword;
         unique case (addr_lo)
            2'd0: merge_data[7:0]   = wdata[BYTE_W-1:0];
            2'd1: merge_data[15:8]  = wdata[BYTE_W-1:0];
            2'd2: merge_data[23:16] = wdata[BYTE_W-1:0];
            2'd3: merge_data[31:24] = wdata[BYTE_W-1:0];
            default: merge_data = rword;
         endcase
      end else if (size == SZ_HALF) begin
         load_data  = {{(WORD_W - HALF_W){sgn & lane_h[HALF_W-1]}}, lane_h};
         merge_data = rword;
         if (addr_lo[1]) begin
            merge_data[31:16] = wdata[HALF_W-1:0];
         end else begin
            merge_data[15:0] = wdata[HALF_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word pipeline requests into single-cycle word
// accesses on a simple memory port. Sub-word stores use read-modify-write.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned requests with
// resp_err instead of silently force-aligning them.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       load result (0 for stores/errors), misalignment flag
//   mem_addr                   word index, zero-extended
//   mem_wdata, mem_rd, mem_wd  memory write data and enables
//   mem_rdata                  combinational memory read data
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32,
   parameter int unsigned IDX_W     = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wd,
   input  logic [31:0] mem_rdata
);

   state_t           state_q, state_d;
   logic             held_we;
   logic [1:0]       held_size;
   logic             held_sgn;
   logic [IDX_W+1:0] held_addr;
   logic [31:0]      held_wdata;
   logic             held_err;
   logic [31:0]      rword_q;

   logic             accept;
   logic             misalign;
   logic [31:0]      load_data;
   logic [31:0]      merge_data;

   // Address bits above the memory index never reach the memory.
   logic unused_req_addr;
   assign unused_req_addr = ^req_addr[31:IDX_W+2];

   assign accept = req_valid && (state_q == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (misalign) begin
                  state_d = ST_RESP;
               end else if (!req_we) begin
                  state_d = ST_READ;
               end else if (req_size[1]) begin
                  state_d = ST_WRITE;
               end else begin
                  // Sub-word store: fetch the word first so the other lanes survive.
                  state_d = ST_READ;
               end
            end
         end
         ST_READ:  state_d = held_we ? ST_WRITE : ST_RESP;
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         held_we    <= 1'b0;
         held_size  <= SZ_BYTE;
         held_sgn   <= 1'b0;
         held_addr  <= '0;
         held_wdata <= '0;
         held_err   <= 1'b0;
         rword_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            held_we    <= req_we;
            held_size  <= req_size;
            held_sgn   <= req_signed;
            held_addr  <= req_addr[IDX_W+1:0];
            held_wdata <= req_wdata;
            held_err   <= misalign;
         end
         if (state_q == ST_READ) begin
            rword_q <= mem_rdata;
         end
      end
   end

   mem_lane_align u_lane_align (
      .size       (held_size),
      .sgn        (held_sgn),
      .addr_lo    (held_addr[1:0]),
      .rword      (rword_q),
      .wdata      (held_wdata),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Handshake and memory enables decode from state only.
   assign req_ready  = (state_q == ST_IDLE);
   assign mem_rd     = (state_q == ST_READ);
   assign mem_wd     = (state_q == ST_WRITE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = resp_valid && held_err;

   assign resp_rdata = (resp_valid && !held_we && !held_err) ? load_data : 32'h0;
   assign mem_wdata  = mem_wd ? merge_data : 32'h0;
   assign mem_addr   = {{(32 - IDX_W){1'b0}}, held_addr[IDX_W+1:2]};

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wd;
   logic [31:0] mem_rdata;

   logic [31:0] mem [32];
   logic        mem_init;

   int vectors = 0;
   int miscompares = 0;
   int rd_cnt = 0;
   int wd_cnt = 0;
   int overlap = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_wd_addr = '0;
   logic [31:0] last_wdata = '0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .MEM_WORDS (32),
      .IDX_W     (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_wd     (mem_wd),
      .mem_rdata  (mem_rdata)
   );

   // Word-indexed memory with combinational read.
   assign mem_rdata = mem[mem_addr[4:0]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0000_0001;
      end else if (mem_wd) begin
         mem[mem_addr[4:0]] <= mem_wdata;
      end
   end

   // Mid-cycle monitor of the memory port.
   always @(negedge clk) begin
      if (mem_rd) begin
         rd_cnt       = rd_cnt + 1;
         last_rd_addr = mem_addr;
      end
      if (mem_wd) begin
         wd_cnt       = wd_cnt + 1;
         last_wd_addr = mem_addr;
         last_wdata   = mem_wdata;
      end
      if (mem_rd && mem_wd) overlap = overlap + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request from IDLE; lat counts edges from accept to the resp_valid cycle.
   task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      step();
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         step();
         lat++;
      end
      rdata = resp_rdata;
      err   = resp_err;
      step();
   endtask

   initial begin
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          rd0, wd0;
      int          acc, nresp, bad_ready;
      int          tresp [4];

      rst        = 1'b1;
      mem_init   = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      step();
      step();

      // Reset state (rst still high)
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wd", 32'(mem_wd), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst      = 1'b0;
      mem_init = 1'b0;
      step();

      // V1: word load at 0x08
      rd0 = rd_cnt; wd0 = wd_cnt;
      xact(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, lat, rdata, err);
      chk("v1_latency", 32'(lat), 32'd2);
      chk("v1_rdata", rdata, 32'h0000_0001);
      chk("v1_err", 32'(err), 32'd0);
      chk("v1_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
      chk("v1_rd_addr", last_rd_addr, 32'd2);
      chk("v1_wd_cycles", 32'(wd_cnt - wd0), 32'd0);

      // V2: word store then signed byte load from the top byte
      rd0 = rd_cnt; wd0 = wd_cnt;
      xact(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rdata, err);
      chk("v2_st_latency", 32'(lat), 32'd2);
      chk("v2_st_rdata", rdata, 32'h0);
      chk("v2_st_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
      chk("v2_st_wd_cycles", 32'(wd_cnt - wd0), 32'd1);
      chk("v2_st_wd_addr", last_wd_addr, 32'd4);
      chk("v2_st_wdata", last_wdata, 32'hDEAD_BEEF);
      chk("v2_mem4", mem[4], 32'hDEAD_BEEF);
      xact(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, lat, rdata, err);
      chk("v2_ld_latency", 32'(lat), 32'd2);
      chk("v2_ld_rdata", rdata, 32'hFFFF_FFDE);
      xact(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, lat, rdata, err);
      chk("v2_ldh_signed", rdata, 32'hFFFF_DEAD);
      xact(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, lat, rdata, err);
      chk("v2_ldb_unsigned", rdata, 32'h0000_00EF);

      // V3: half store into upper lane of word 1 (read-modify-write)
      rd0 = rd_cnt; wd0 = wd_cnt;
      xact(1'b1, SZ_HALF, 1'b0, 32'h06, 32'h0000_1234, lat, rdata, err);
      chk("v3_latency", 32'(lat), 32'd3);
      chk("v3_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
      chk("v3_wd_cycles", 32'(wd_cnt - wd0), 32'd1);
      chk("v3_wdata", last_wdata, 32'h1234_0001);
      chk("v3_wd_addr", last_wd_addr, 32'd1);
      xact(1'b0, SZ_HALF, 1'b0, 32'h06, 32'h0, lat, rdata, err);
      chk("v3_ld_rdata", rdata, 32'h0000_1234);
      xact(1'b1, SZ_BYTE, 1'b0, 32'h05, 32'hFFFF_FFAB, lat, rdata, err);
      chk("v3_byte_st_latency", 32'(lat), 32'd3);
      chk("v3_mem1", mem[1], 32'h1234_AB01);

      // V4: reset during READ of a byte store to word 3
      wd0 = wd_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_size   = SZ_BYTE;
      req_signed = 1'b0;
      req_addr   = 32'h0C;
      req_wdata  = 32'h55;
      step();
      req_valid = 1'b0;
      chk("v4_in_read", 32'(mem_rd), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("v4_ready_after_rst", 32'(req_ready), 32'd1);
      chk("v4_no_wd_after_rst", 32'(mem_wd), 32'd0);
      step();
      step();
      step();
      chk("v4_wd_cycles", 32'(wd_cnt - wd0), 32'd0);
      chk("v4_mem3", mem[3], 32'h0000_0001);

      // V5: req_valid held high for three word loads of word 1
      rd0 = rd_cnt;
      acc = 0; nresp = 0; bad_ready = 0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = 32'h04;
      for (int c = 0; c < 15; c++) begin
         if (resp_valid) begin
            if (nresp < 4) tresp[nresp] = c;
            nresp++;
            if (resp_rdata !== 32'h1234_AB01) bad_ready++;
         end
         if (resp_valid && req_ready) bad_ready++;
         if (req_ready && req_valid) acc++;
         if (acc == 3 && !req_ready) req_valid = 1'b0;
         step();
      end
      req_valid = 1'b0;
      chk("v5_accepts", 32'(acc), 32'd3);
      chk("v5_resp_count", 32'(nresp), 32'd3);
      chk("v5_bad_ready_or_data", 32'(bad_ready), 32'd0);
      chk("v5_first_resp", 32'(tresp[0]), 32'd2);
      chk("v5_gap1", 32'(tresp[1] - tresp[0]), 32'd3);
      chk("v5_gap2", 32'(tresp[2] - tresp[1]), 32'd3);
      chk("v5_rd_cycles", 32'(rd_cnt - rd0), 32'd3);

      // V6: misaligned word load at 0x0A
      rd0 = rd_cnt; wd0 = wd_cnt;
      xact(1'b0, SZ_WORD, 1'b0, 32'h0A, 32'h0, lat, rdata, err);
`ifdef MEM_ALIGN_CHECK_EN
      chk("v6_latency", 32'(lat), 32'd1);
      chk("v6_err", 32'(err), 32'd1);
      chk("v6_rdata", rdata, 32'h0);
      chk("v6_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
      chk("v6_wd_cycles", 32'(wd_cnt - wd0), 32'd0);
`else
      chk("v6_latency", 32'(lat), 32'd2);
      chk("v6_err", 32'(err), 32'd0);
      chk("v6_rdata", rdata, 32'h0000_0001);
      chk("v6_rd_addr", last_rd_addr, 32'd2);
      xact(1'b0, SZ_HALF, 1'b0, 32'h07, 32'h0, lat, rdata, err);
      chk("v6_half_odd", rdata, 32'h0000_1234);
`endif

      chk("no_rd_wd_overlap", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 32, meaning the number of 32-bit words in the downstream data memory.
REQ-002 The block SHALL have parameter IDX_W, default 5, meaning the word-index width; it equals clog2(MEM_WORDS).
REQ-003 The block SHALL have one clock, `clk`; reset is synchronous and active-high, named `rst`.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  pipeline memory request
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  load result, extended to 32 bits
- resp_err  out  1  misaligned request
- mem_addr  out  32  word index, zero-extended
- mem_wdata  out  32  full word to memory
- mem_rd  out  1  memory read enable
- mem_wd  out  1  memory write enable
- mem_rdata  in  32  combinational read data from memory

Function
REQ-005 The block SHALL implement a Moore FSM with states IDLE, READ, WRITE and RESP; mem_rd, mem_wd and req_ready SHALL decode from the state only.
REQ-006 req_ready SHALL be 1 only in IDLE; on accept, the block SHALL latch we, size, signed, addr and wdata into holding registers.
REQ-007 The FSM SHALL take these transitions out of IDLE on accept:
- load → READ
- word store → WRITE
- byte or half store → READ (read-modify-write)
REQ-008 In READ, the block SHALL assert mem_rd=1 and capture mem_rdata at the clock edge that ends the state; it SHALL then go to RESP for a load and to WRITE for a sub-word store.
REQ-009 In WRITE, the block SHALL assert mem_wd=1 for exactly one cycle and then go to RESP.
- Word store: mem_wdata is the held wdata.
- Sub-word store: mem_wdata is the captured word with the addressed byte (addr[1:0]) or half (addr[1]) lane replaced.
REQ-010 In RESP, the block SHALL assert resp_valid for one cycle and return to IDLE; the response has no backpressure.
REQ-011 mem_addr SHALL equal held_addr[IDX_W+1:2]; the block SHALL drive higher address bits as zero.
REQ-012 For loads, resp_rdata SHALL be the extracted lane, sign-extended when signed=1 and zero-extended otherwise; for stores, resp_rdata SHALL be 0.
REQ-013 Latency from the accept edge SHALL be:
- load: resp_valid in cycle T+2
- word store: resp_valid in cycle T+2
- sub-word store: resp_valid in cycle T+3
- maximum throughput: one request per 3 (or 4) cycles
REQ-014 mem_rd and mem_wd SHALL never both be high; outside READ and WRITE, both SHALL be 0.
REQ-015 req_valid held high in RESP SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-016 With rst=1 at a clock edge, the block SHALL go to IDLE and clear the holding registers.
- Reset outputs: req_ready=1; resp_valid, resp_err, mem_rd, mem_wd = 0; resp_rdata, mem_addr, mem_wdata = 0.
REQ-017 Reset in any state SHALL abort the operation with no write issued afterward; a write whose WRITE cycle already completed stays in memory.

Configuration
REQ-018 With macro MEM_ALIGN_CHECK_EN defined, the block SHALL flag misaligned requests (half with addr[0]=1, word with addr[1:0]≠0).
- IDLE goes directly to RESP with no memory access.
- Response: resp_err=1, resp_rdata=0.
REQ-019 Without MEM_ALIGN_CHECK_EN, resp_err SHALL be tied to 0, low address bits SHALL be ignored (words force-aligned, halves use addr[1]), and the port list SHALL be unchanged.

Structure
REQ-020 Package mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the lane-extract/merge width constants.
REQ-021 The block SHALL contain one combinational sub-module, mem_lane_align, which performs load lane extraction/extension and store lane merge.

Verification
REQ-022 The bench SHALL cover these scenarios; the memory model is word-indexed, 32 words, initialised to 0x00000001, with combinational read.
- V1: After reset, a word load at 0x08 → resp_valid at T+2, resp_rdata=0x00000001, exactly one mem_rd cycle with mem_addr=2, no mem_wd.
- V2: A word store of 0xDEADBEEF at 0x10, then a signed byte load at 0x13 → write at mem_addr=4; load returns 0xFFFFFFDE.
- V3: A half store of 0x1234 at 0x06 onto word 0x00000001 → READ then WRITE, mem_wdata=0x12340001, resp_valid at T+3; an unsigned half load at 0x06 returns 0x00001234.
- V4: Assert rst during READ of a byte store → no mem_wd ever, state IDLE and req_ready=1 next cycle, target word unchanged.
- V5: req_valid held high continuously for three loads → accepts only in IDLE, three resp_valid pulses spaced 3 cycles apart, mem_rd/mem_wd never overlap.
- V6 (MEM_ALIGN_CHECK_EN): a word load at 0x0A → resp_err=1, resp_rdata=0 at T+1, no memory enables; without the macro, the same request returns word 2 with resp_err=0.
